// File: rtl/dadda_arb_pkg.sv
// Shared constants, types and helpers for the multiplier round-robin arbiter.
// The DADDA_ARB_PERF_EN build adds per-requester grant counters to the top.
package dadda_arb_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned PROD_W = 8;

    typedef logic signed [OPND_W-1:0] opnd_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef enum logic {SlotEmpty, SlotFull} slot_e;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/dadda_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping around, returned as a one-hot grant plus encoded index.
module dadda_arb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/dadda_signed_multiplier_4.sv
// 4x4 signed combinational multiplier: Baugh-Wooley partial products summed to
// an 8-bit two's-complement product.
module dadda_signed_multiplier_4 (
    output logic [7:0] product,
    input  logic [3:0] A,
    input  logic [3:0] B
);

    logic [3:0][3:0] row;

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            // Sign-row/sign-column terms are inverted; the 8'h90 constant completes it.
            if ((i == 3) != (j == 3)) begin : g_inv
                assign row[i][j] = ~(A[j] & B[i]);
            end else begin : g_pos
                assign row[i][j] = A[j] & B[i];
            end
        end
    end

    assign product = {4'b0000, row[0]}
                   + {3'b000, row[1], 1'b0}
                   + {2'b00, row[2], 2'b00}
                   + {1'b0, row[3], 3'b000}
                   + 8'h90;

endmodule

// File: rtl/dadda_mult4_rr_arbiter.sv
// Round-robin sharing of one 4x4 signed multiplier among NUM_REQ requesters.
// Define DADDA_ARB_PERF_EN to add perf_clr and saturating grant_cnt counters.
module dadda_mult4_rr_arbiter
    import dadda_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_product,
    output logic [ID_W-1:0]        rsp_id
`ifdef DADDA_ARB_PERF_EN
    ,
    input  logic                   perf_clr,
    output logic [16*NUM_REQ-1:0]  grant_cnt
`endif
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               slot_free;
    logic               fire;

    slot_e              slot_q, slot_d;
    prod_t              prod_q, prod_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    opnd_t              mul_a, mul_b;
    prod_t              mul_p;

    // A full slot still accepts when it drains this cycle.
    assign slot_free = (slot_q == SlotEmpty) | rsp_ready;

    dadda_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .enable (rst_n & slot_free),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[4*i +: 4];
                mul_b = req_b[4*i +: 4];
            end
        end
    end

    dadda_signed_multiplier_4 u_mult (
        .product (mul_p),
        .A       (mul_a),
        .B       (mul_b)
    );

    always_comb begin
        slot_d   = slot_q;
        prod_d   = prod_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            slot_d   = SlotFull;
            prod_d   = mul_p;
            id_d     = grant_idx;
            rr_ptr_d = ID_W'(rr_next(32'(grant_idx), NUM_REQ));
        end else if (rsp_ready) begin
            slot_d = SlotEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q   <= SlotEmpty;
            prod_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            slot_q   <= slot_d;
            prod_q   <= prod_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid   = (slot_q == SlotFull);
    assign rsp_product = prod_q;
    assign rsp_id      = id_q;

`ifdef DADDA_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [15:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n || perf_clr) begin
                cnt_q <= '0;
            end else if (grant[i] && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign grant_cnt[16*i +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_dadda_mult4_rr_arbiter.sv
// Self-checking bench: behavioural arbiter/multiplier model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_dadda_mult4_rr_arbiter;

    localparam int NREQ = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_product;
    logic [1:0]  rsp_id;
`ifdef DADDA_ARB_PERF_EN
    logic        perf_clr;
    logic [63:0] grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    dadda_mult4_rr_arbiter #(
        .NUM_REQ (4),
        .ID_W    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
`ifdef DADDA_ARB_PERF_EN
        ,
        .perf_clr    (perf_clr),
        .grant_cnt   (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the result slot and the priority pointer.
    bit         m_valid = 1'b0;
    logic [7:0] m_prod  = 8'h00;
    int         m_id    = 0;
    int         m_ptr   = 0;

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {{4{a[3]}}, a};
        eb = {{4{b[3]}}, b};
        return ea * eb;
    endfunction

    function automatic int pick();
        if (!rst_n || (m_valid && !rsp_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_prod  = 8'h00;
            m_id    = 0;
            m_ptr   = 0;
        end else begin
            w = pick();
            if (w >= 0) begin
                m_prod  = smul(req_a[4*w +: 4], req_b[4*w +: 4]);
                m_id    = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % NREQ;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int         w;
        logic [3:0] exp_rdy;
        if (chk_en) begin
            exp_rdy = 4'b0000;
            w = pick();
            if (w >= 0) exp_rdy[w] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
            check("rsp_product", 64'(rsp_product), 64'(m_prod));
            check("rsp_id", 64'(rsp_id), 64'(m_id));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    int cnt_id [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b1;
`ifdef DADDA_ARB_PERF_EN
        perf_clr  = 1'b0;
`endif
        step();
        chk_en = 1'b1;
        step();
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_prod", 64'(rsp_product), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
        check("reset_ready", 64'(req_ready), 64'd0);

        // Single requester.
        rst_n = 1'b1;
        set_req(0, 4'b0010, 4'b0011);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 4'b0000;
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_prod", 64'(rsp_product), 64'h06);
        check("t1_id", 64'(rsp_id), 64'd0);

        // Signed corner cases on requester 2.
        begin
            logic [3:0] av [4];
            logic [3:0] bv [4];
            logic [7:0] pv [4];
            av = '{4'b1010, 4'b1101, 4'b1000, 4'b1000};
            bv = '{4'b0011, 4'b1010, 4'b1000, 4'b0111};
            pv = '{8'hEE, 8'h12, 8'h40, 8'hC8};
            for (int i = 0; i < 4; i++) begin
                set_req(2, av[i], bv[i]);
                req_valid = 4'b0100;
                step();
                check("t2_prod", 64'(rsp_product), 64'(pv[i]));
                check("t2_id", 64'(rsp_id), 64'd2);
            end
            req_valid = 4'b0000;
            step();
            check("t2_drain", 64'(rsp_valid), 64'd0);
        end

        // Fairness from a fresh pointer.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'(i + 1), 4'(i + 1));
            cnt_id[i] = 0;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t3_id", 64'(rsp_id), 64'(i % 4));
            if (rsp_valid) cnt_id[rsp_id]++;
        end
        check("t3_prod_last", 64'(rsp_product), 64'h10);
        for (int i = 0; i < 4; i++) check("t3_count", 64'(cnt_id[i]), 64'd2);
        req_valid = 4'b0000;
        step();

        // Backpressure: result held, no grants, then same-cycle replacement.
        set_req(0, 4'b0010, 4'b0011);
        req_valid = 4'b0001;
        step();
        check("t4_first", 64'(rsp_product), 64'h06);
        rsp_ready = 1'b0;
        set_req(1, 4'b0001, 4'b0101);
        req_valid = 4'b0010;
        #1;
        check("t4_ready0", 64'(req_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_prod", 64'(rsp_product), 64'h06);
            check("t4_hold_valid", 64'(rsp_valid), 64'd1);
            check("t4_hold_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_release_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 4'b0000;
        check("t4_new_prod", 64'(rsp_product), 64'h05);
        check("t4_new_id", 64'(rsp_id), 64'd1);
        step();
        check("t4_no_dup", 64'(rsp_valid), 64'd0);

        // Reset while holding a result.
        set_req(0, 4'b1010, 4'b0011);
        req_valid = 4'b0001;
        step();
        check("t5_full", 64'(rsp_product), 64'hEE);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        step();
        check("t5_valid", 64'(rsp_valid), 64'd0);
        check("t5_prod", 64'(rsp_product), 64'd0);
        check("t5_id", 64'(rsp_id), 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("t5_ready", 64'(req_ready), 64'h2);
        step();
        check("t5_first_id", 64'(rsp_id), 64'd1);
        step();
        check("t5_second_id", 64'(rsp_id), 64'd3);
        req_valid = 4'b0000;
        step();

`ifdef DADDA_ARB_PERF_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(3, 4'b0001, 4'b0001);
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) step();
        req_valid = 4'b0000;
        check("t6_count", grant_cnt, {16'd5, 48'd0});
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("t6_clear", grant_cnt, 64'd0);
        perf_clr = 1'b1;
        req_valid = 4'b1000;
        step();
        perf_clr = 1'b0;
        req_valid = 4'b0000;
        check("t6_clear_wins", grant_cnt, 64'd0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dadda_mult4_rr_arbiter.md
Name: dadda_mult4_rr_arbiter

Overview:
Shares one combinational dadda_signed_multiplier_4 (4x4 signed, 8-bit product) among NUM_REQ independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the product is captured in a single output register with the winner's ID. The block sits between client engines (filters, MAC sequencers) and the shared multiplier datapath.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
ID_W, $clog2(NUM_REQ), width of rsp_id

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  4*NUM_REQ  signed multiplicand, requester i at [4i+3:4i]
req_b  input  4*NUM_REQ  signed multiplier, same packing
rsp_valid  output  1  output register holds a result
rsp_ready  input  1  downstream accepts result
rsp_product  output  8  signed product A*B, two's complement
rsp_id  output  ID_W  index of requester that produced rsp_product

Behaviour:
- Reset (rst_n=0 at clk edge):
  - rsp_valid=0, rsp_product=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 combinationally while rst_n=0.
  - A reset mid-transaction discards the held result.
- Output slot states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- slot_free = !rsp_valid | rsp_ready. Bypass-drain gives full throughput of one result per cycle.
- Grant (combinational):
  - Applies only when slot_free and rst_n=1.
  - Winner = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1 (wrap-around).
  - req_ready[winner]=1; all other bits 0.
  - If no req_valid is set, or the slot is not free, req_ready=0.
- Operands of the winner are muxed to the multiplier's A/B ports. With no grant, A=B=0.
- On a handshake (req_valid[i] & req_ready[i]) at the clk edge:
  - rsp_product <= multiplier product.
  - rsp_id <= i.
  - rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: one cycle from accept to rsp_valid.
- If rsp_valid & rsp_ready with no new grant, rsp_valid <= 0 and rsp_product/rsp_id hold their last values.
- If rsp_valid & rsp_ready and a new grant occur in the same cycle, the new result replaces the old one with no bubble.
- If rsp_valid=1 and rsp_ready=0:
  - rsp_product and rsp_id stay stable.
  - req_ready is all zero.
  - rr_ptr is unchanged.
- rr_ptr changes only on a handshake. Idle cycles do not rotate priority.
- Arithmetic: the full 8-bit signed product has no overflow. The corner case -8*-8 = +64 (8'h40) is included.
- Requesters must hold req_a/req_b stable while req_valid=1 and not yet accepted. The block does not check this.

Optional Feature:
Macro DADDA_ARB_PERF_EN.
- Defined:
  - Adds output port grant_cnt, 16*NUM_REQ bits.
  - One 16-bit saturating counter per requester, incremented on each handshake of that requester.
  - Counters hold at 16'hFFFF and reset to 0 on rst_n=0.
  - Adds input perf_clr (1 bit). When high, it zeroes all counters synchronously. If perf_clr coincides with a handshake, the counter is cleared (clear wins).
- Undefined: no ports, no counters; behaviour is otherwise identical.

Decomposition:
- Package dadda_arb_pkg holds:
  - Constants OPND_W=4 and PROD_W=8.
  - Typedefs opnd_t (logic signed [3:0]) and prod_t (logic signed [7:0]).
  - Function rr_next(idx, n) implementing the wrap-around increment.
- One sub-module, dadda_arb_rr_pick: a combinational round-robin picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index.
- The top instantiates dadda_arb_rr_pick, dadda_signed_multiplier_4 (ports product, A, B), and the output register/FSM.

Test Plan:
1. Single requester: req0 valid with A=4'b0010, B=4'b0011, rsp_ready=1 -> next cycle rsp_valid=1, product=8'h06, id=0; rr_ptr=1.
2. Signed cases through req2:
   - -6*3 (4'b1010, 4'b0011) -> 8'hEE.
   - -3*-6 (4'b1101, 4'b1010) -> 8'h12.
   - -8*-8 -> 8'h40.
   - -8*7 -> 8'hC8.
   - All results carry id=2.
3. Fairness: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; each id appears exactly twice in 8 results.
4. Backpressure: rsp_ready=0 for 3 cycles while holding 2*3 -> product 8'h06 stable and req_ready=0 throughout. On release, the next grant lands in the same cycle with no lost or duplicated result.
5. Reset mid-op: rsp_valid=1 with product 8'hEE, then rst_n=0 for one edge -> rsp_valid=0, product=0, id=0, rr_ptr=0. After reset, req1 and req3 both valid -> req1 is granted first.
6. With DADDA_ARB_PERF_EN:
   - 5 handshakes on req3 -> grant_cnt[3]=5, others 0.
   - perf_clr pulse -> all counters 0.
   - Preloaded saturation -> the counter stays at 16'hFFFF.
